// File: rtl/traffic_pkg.sv
// Shared types and helpers for the multi-approach traffic light controller.
package traffic_pkg;

   typedef enum logic [2:0] {
      OFF     = 3'd0,
      ALL_RED = 3'd1,
      GREEN   = 3'd2,
      YELLOW  = 3'd3,
      WALK    = 3'd4,
      FLASH   = 3'd5
   } phase_t;

   localparam logic [1:0] LAMP_OFF    = 2'b00;
   localparam logic [1:0] LAMP_RED    = 2'b01;
   localparam logic [1:0] LAMP_YELLOW = 2'b10;
   localparam logic [1:0] LAMP_GREEN  = 2'b11;

   function automatic int unsigned dir_next(input int unsigned cur, input int unsigned num_dir);
      if (cur >= num_dir - 32'd1) begin
         return 32'd0;
      end else begin
         return cur + 32'd1;
      end
   endfunction

endpackage

// File: rtl/traffic_light_multi_timer.sv
// Tick-driven down-counter timing each controller phase; a load beats a decrement.
module phase_timer #(
   parameter int TW = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   input  logic          tick,
   output logic [TW-1:0] value,
   output logic          done
);

   logic [TW-1:0] count_r;

   // Phase counter: load on phase entry, count down on tick until zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= load_val;
      end else if (tick && (count_r != '0)) begin
         count_r <= count_r - TW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign value = count_r;
   assign done  = (count_r == '0);

endmodule

// File: rtl/traffic_light_multi.sv
// Round-robin traffic light for NUM_DIR approaches with green extension and
// an exclusive all-red pedestrian walk/flash phase.
module traffic_light_multi
   import traffic_pkg::*;
#(
   parameter int NUM_DIR   = 2,
   parameter int TW        = 6,
   parameter int RED_CLR   = 2,
   parameter int YELLOW_T  = 3,
   parameter int GREEN_MIN = 10,
   parameter int GREEN_EXT = 4,
   parameter int GREEN_MAX = 30,
   parameter int WALK_T    = 8,
   parameter int FLASH_T   = 4,
   localparam int DW       = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 tick,
   input  logic [NUM_DIR-1:0]   car_present,
   input  logic [NUM_DIR-1:0]   ped_req,
   output logic [2*NUM_DIR-1:0] L_out,
   output logic [NUM_DIR-1:0]   walk,
   output logic                 ped_flash,
   output logic [DW-1:0]        active_dir,
   output logic [2:0]           phase
);

   phase_t              phase_r;
   phase_t              phase_nxt_s;
   logic [DW-1:0]       active_dir_r;
   logic [TW-1:0]       green_cnt_r;
   logic [NUM_DIR-1:0]  ped_pend_r;
   logic [NUM_DIR-1:0]  walk_mask_r;
   logic                after_walk_r;
   logic                first_r;
   logic                ped_flash_r;

   logic                load_s;
   logic [TW-1:0]       load_val_s;
   logic [TW-1:0]       timer_val_s;
   logic                done_s;
   logic                enter_green_s;
   logic                enter_walk_s;
   logic                enter_flash_s;
   logic                flash_end_s;
   logic                extend_s;
   logic                leave_off_s;
   logic                ext_ok_s;
   logic [NUM_DIR-1:0]  others_s;
   logic [TW:0]         ext_sum_s;

   phase_timer #(.TW(TW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (load_s),
      .load_val (load_val_s),
      .tick     (tick),
      .value    (timer_val_s),
      .done     (done_s)
   );

   // Extension only while the active approach alone has traffic and nobody waits to cross
   always_comb begin
      others_s  = car_present & ~(NUM_DIR'(1) << active_dir_r);
      ext_sum_s = {1'b0, green_cnt_r} + (TW+1)'(GREEN_EXT);
      ext_ok_s  = car_present[active_dir_r] && (others_s == '0) && (ped_pend_r == '0)
                  && (ext_sum_s <= (TW+1)'(GREEN_MAX));
   end

   // Next-phase selection and timer load requests
   always_comb begin
      phase_nxt_s   = phase_r;
      load_s        = 1'b0;
      load_val_s    = '0;
      enter_green_s = 1'b0;
      enter_walk_s  = 1'b0;
      enter_flash_s = 1'b0;
      flash_end_s   = 1'b0;
      extend_s      = 1'b0;
      leave_off_s   = 1'b0;
      case (phase_r)
         OFF: begin
            if (start) begin
               phase_nxt_s = ALL_RED;
               load_s      = 1'b1;
               load_val_s  = TW'(RED_CLR);
               leave_off_s = 1'b1;
            end else begin
               phase_nxt_s = OFF;
            end
         end
         ALL_RED: begin
            if (done_s && (ped_pend_r != '0) && !after_walk_r) begin
               phase_nxt_s  = WALK;
               load_s       = 1'b1;
               load_val_s   = TW'(WALK_T);
               enter_walk_s = 1'b1;
            end else if (done_s) begin
               phase_nxt_s   = GREEN;
               load_s        = 1'b1;
               load_val_s    = TW'(GREEN_MIN);
               enter_green_s = 1'b1;
            end else begin
               phase_nxt_s = ALL_RED;
            end
         end
         GREEN: begin
            if (done_s && ext_ok_s) begin
               load_s     = 1'b1;
               load_val_s = TW'(GREEN_EXT);
               extend_s   = 1'b1;
            end else if (done_s) begin
               phase_nxt_s = YELLOW;
               load_s      = 1'b1;
               load_val_s  = TW'(YELLOW_T);
            end else begin
               phase_nxt_s = GREEN;
            end
         end
         YELLOW: begin
            if (done_s) begin
               phase_nxt_s = ALL_RED;
               load_s      = 1'b1;
               load_val_s  = TW'(RED_CLR);
            end else begin
               phase_nxt_s = YELLOW;
            end
         end
         WALK: begin
            if (done_s) begin
               phase_nxt_s   = FLASH;
               load_s        = 1'b1;
               load_val_s    = TW'(FLASH_T);
               enter_flash_s = 1'b1;
            end else begin
               phase_nxt_s = WALK;
            end
         end
         FLASH: begin
            if (done_s) begin
               phase_nxt_s = ALL_RED;
               load_s      = 1'b1;
               load_val_s  = TW'(RED_CLR);
               flash_end_s = 1'b1;
            end else begin
               phase_nxt_s = FLASH;
            end
         end
         default: begin
            phase_nxt_s = OFF;
         end
      endcase
   end

   // Phase state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_r <= OFF;
      end else begin
         phase_r <= phase_nxt_s;
      end
   end

   // Green ownership: the first green after OFF always goes to approach 0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_dir_r <= '0;
         green_cnt_r  <= '0;
         first_r      <= 1'b0;
         after_walk_r <= 1'b0;
      end else begin
         if (leave_off_s) begin
            first_r <= 1'b1;
         end else if (enter_green_s) begin
            first_r <= 1'b0;
         end else begin
            first_r <= first_r;
         end
         if (enter_green_s) begin
            active_dir_r <= first_r ? '0 : DW'(dir_next(32'(active_dir_r), 32'(NUM_DIR)));
            green_cnt_r  <= TW'(GREEN_MIN);
         end else if (extend_s) begin
            green_cnt_r  <= ext_sum_s[TW-1:0];
         end else begin
            green_cnt_r  <= green_cnt_r;
         end
         if (flash_end_s) begin
            after_walk_r <= 1'b1;
         end else if (enter_green_s) begin
            after_walk_r <= 1'b0;
         end else begin
            after_walk_r <= after_walk_r;
         end
      end
   end

   // Pedestrian request latch; the walk mask also takes requests arriving on the entry edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ped_pend_r  <= '0;
         walk_mask_r <= '0;
      end else if (phase_r == OFF) begin
         ped_pend_r  <= ped_pend_r;
         walk_mask_r <= walk_mask_r;
      end else if (enter_walk_s) begin
         ped_pend_r  <= '0;
         walk_mask_r <= ped_pend_r | ped_req;
      end else begin
         ped_pend_r  <= ped_pend_r | ped_req;
         walk_mask_r <= walk_mask_r;
      end
   end

   // Don't-walk flasher toggles whenever the flash timer steps
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ped_flash_r <= 1'b0;
      end else if (enter_flash_s) begin
         ped_flash_r <= 1'b1;
      end else if (flash_end_s) begin
         ped_flash_r <= 1'b0;
      end else if ((phase_r == FLASH) && tick && (timer_val_s != '0)) begin
         ped_flash_r <= ~ped_flash_r;
      end else begin
         ped_flash_r <= ped_flash_r;
      end
   end

   // Lamp and walk decode from the registered state
   always_comb begin
      L_out = '0;
      walk  = '0;
      for (int i = 0; i < NUM_DIR; i++) begin
         case (phase_r)
            OFF:     L_out[2*i +: 2] = LAMP_OFF;
            GREEN:   L_out[2*i +: 2] = (DW'(i) == active_dir_r) ? LAMP_GREEN : LAMP_RED;
            YELLOW:  L_out[2*i +: 2] = (DW'(i) == active_dir_r) ? LAMP_YELLOW : LAMP_RED;
            ALL_RED, WALK, FLASH: L_out[2*i +: 2] = LAMP_RED;
            default: L_out[2*i +: 2] = LAMP_OFF;
         endcase
      end
      if (phase_r == WALK) begin
         walk = walk_mask_r;
      end else begin
         walk = '0;
      end
   end

   assign ped_flash  = ped_flash_r;
   assign active_dir = active_dir_r;
   assign phase      = phase_r;

endmodule

// File: tb/tb_traffic_light_multi.sv
// Scoreboard bench: expected per-cycle outputs are queued from phase durations and compared each cycle.
module tb_traffic_light_multi;
   import traffic_pkg::*;

   logic       clk;
   logic       reset;
   logic       start;
   logic       tick;
   logic [1:0] car_present;
   logic [1:0] ped_req;
   logic [3:0] L_out;
   logic [1:0] walk;
   logic       ped_flash;
   logic [0:0] active_dir;
   logic [2:0] phase;

   typedef struct {
      string       tag;
      logic [10:0] v;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   traffic_light_multi dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .tick        (tick),
      .car_present (car_present),
      .ped_req     (ped_req),
      .L_out       (L_out),
      .walk        (walk),
      .ped_flash   (ped_flash),
      .active_dir  (active_dir),
      .phase       (phase)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (phase,L_out,walk,flash,dir)", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] mk(input phase_t ph, input logic [3:0] l, input logic [1:0] w,
                                      input logic f, input logic d);
      return {ph, l, w, f, d};
   endfunction

   function automatic logic [10:0] obs();
      return {phase, L_out, walk, ped_flash, active_dir};
   endfunction

   task automatic push_n(input string tag, input logic [10:0] v, input int n);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      for (int i = 0; i < n; i++) sb_q.push_back(e);
   endtask

   task automatic push_allred(input string t, input logic d);
      push_n(t, mk(ALL_RED, 4'b0101, 2'b00, 1'b0, d), 3);
   endtask

   task automatic push_green(input string t, input logic d, input int n);
      push_n(t, mk(GREEN, d ? 4'b1101 : 4'b0111, 2'b00, 1'b0, d), n);
   endtask

   task automatic push_yellow(input string t, input logic d, input int n);
      push_n(t, mk(YELLOW, d ? 4'b1001 : 4'b0110, 2'b00, 1'b0, d), n);
   endtask

   task automatic push_walk(input string t, input logic d, input logic [1:0] w);
      push_n(t, mk(WALK, 4'b0101, w, 1'b0, d), 9);
   endtask

   task automatic push_flash(input string t, input logic d);
      for (int i = 0; i < 5; i++) push_n(t, mk(FLASH, 4'b0101, 2'b00, (i % 2) == 0, d), 1);
   endtask

   // Pop one expectation per cycle, sampled 1 time unit after the active edge
   task automatic run_sb();
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check_val(e.tag, 32'(obs()), 32'(e.v));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      start = 1'b0;
      tick  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_state", 32'(obs()), 32'(mk(OFF, 4'b0000, 2'b00, 1'b0, 1'b0)));
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; tick = 1'b1; car_present = 2'b00; ped_req = 2'b00;
      #2;

      // Basic round-robin, no traffic
      do_reset();
      do_start();
      push_allred("t1_allred", 1'b0);
      push_green("t1_green0", 1'b0, 11);
      push_yellow("t1_yellow0", 1'b0, 4);
      push_allred("t1_allred2", 1'b0);
      push_green("t1_green1", 1'b1, 11);
      run_sb();

      // Extension up to the cap on the sole busy approach
      car_present = 2'b01;
      do_reset();
      do_start();
      push_allred("t2_allred", 1'b0);
      push_green("t2_green0_ext", 1'b0, 36);
      push_yellow("t2_yellow0", 1'b0, 4);
      push_allred("t2_allred2", 1'b0);
      push_green("t2_green1", 1'b1, 11);
      run_sb();

      // Competing traffic blocks extension
      car_present = 2'b11;
      do_reset();
      do_start();
      push_allred("t3_allred", 1'b0);
      push_green("t3_green0", 1'b0, 11);
      push_yellow("t3_yellow0", 1'b0, 4);
      push_allred("t3_allred2", 1'b0);
      push_green("t3_green1", 1'b1, 11);
      push_yellow("t3_yellow1", 1'b1, 4);
      push_allred("t3_allred3", 1'b1);
      push_green("t3_green0b", 1'b0, 11);
      run_sb();

      // Pedestrian walk, flash, anti-starvation, then the held request
      car_present = 2'b11;
      do_reset();
      do_start();
      push_allred("t4_allred", 1'b0);
      push_green("t4_green0", 1'b0, 11);
      push_yellow("t4_yellow0", 1'b0, 4);
      push_allred("t4_allred2", 1'b0);
      push_walk("t4_walk1", 1'b0, 2'b10);
      push_flash("t4_flash1", 1'b0);
      push_allred("t4_allred3", 1'b0);
      push_green("t4_green1", 1'b1, 11);
      push_yellow("t4_yellow1", 1'b1, 4);
      push_allred("t4_allred4", 1'b1);
      push_walk("t4_walk0", 1'b1, 2'b01);
      push_flash("t4_flash0", 1'b1);
      push_allred("t4_allred5", 1'b1);
      push_green("t4_green0b", 1'b0, 11);
      fork
         run_sb();
         begin
            repeat (5) @(posedge clk);
            #1 ped_req = 2'b10;
            @(posedge clk);
            #1 ped_req = 2'b00;
            repeat (18) @(posedge clk);
            #1 ped_req = 2'b01;
            repeat (2) @(posedge clk);
            #1 ped_req = 2'b00;
         end
      join

      // Tick held low mid-yellow freezes the phase
      car_present = 2'b00;
      do_reset();
      do_start();
      push_allred("t5_allred", 1'b0);
      push_green("t5_green0", 1'b0, 11);
      push_yellow("t5_yellow_frozen", 1'b0, 54);
      push_allred("t5_allred2", 1'b0);
      push_green("t5_green1", 1'b1, 11);
      fork
         run_sb();
         begin
            repeat (15) @(posedge clk);
            #1 tick = 1'b0;
            repeat (50) @(posedge clk);
            #1 tick = 1'b1;
         end
      join

      // Asynchronous reset mid-green clears everything including pending walk
      do_reset();
      do_start();
      push_allred("t6_allred", 1'b0);
      push_green("t6_green0", 1'b0, 5);
      fork
         run_sb();
         begin
            repeat (4) @(posedge clk);
            #1 ped_req = 2'b01;
            @(posedge clk);
            #1 ped_req = 2'b00;
         end
      join
      #2 reset = 1'b0;
      #1;
      check_val("t6_async_reset", 32'(obs()), 32'(mk(OFF, 4'b0000, 2'b00, 1'b0, 1'b0)));
      @(posedge clk);
      #1 reset = 1'b1;
      push_n("t6_hold_off", mk(OFF, 4'b0000, 2'b00, 1'b0, 1'b0), 10);
      run_sb();
      do_start();
      push_allred("t6_allred_after", 1'b0);
      push_green("t6_green0_after", 1'b0, 11);
      run_sb();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/traffic_light_multi.md
Name: traffic_light_multi

Overview:
Parametrised successor of the single-approach smart traffic light controller. It serves NUM_DIR vehicle approaches in round-robin green order and has an integrated tick-driven phase timer, in place of the earlier external-timer handshake. Green time extends while cars wait on the active approach only. Latched pedestrian requests are served in an exclusive all-red walk phase, followed by a flashing clearance phase. It sits between the sensor front-end and the lamp drivers, and is clocked by the system clock with a slow tick strobe as its timebase.

Parameters:
NUM_DIR, 2, number of vehicle approaches (legal 2..8)
TW, 6, phase timer width
RED_CLR, 2, all-red clearance duration in ticks
YELLOW_T, 3, yellow duration in ticks
GREEN_MIN, 10, initial green duration in ticks
GREEN_EXT, 4, per-extension green increment in ticks
GREEN_MAX, 30, green duration cap in ticks (GREEN_MAX >= GREEN_MIN; all durations >= 1 and < 2**TW)
WALK_T, 8, walk duration in ticks
FLASH_T, 4, pedestrian flash clearance duration in ticks

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  leaves OFF; sampled only in OFF
tick  in  1  one-cycle timebase strobe
car_present  in  NUM_DIR  per-approach vehicle sensor
ped_req  in  NUM_DIR  per-approach pedestrian button, level or pulse
L_out  out  2*NUM_DIR  lamp code per approach, [2i+1:2i]: 00 off, 01 red, 10 yellow, 11 green
walk  out  NUM_DIR  walk lamp per approach
ped_flash  out  1  flashing don't-walk
active_dir  out  max(1,$clog2(NUM_DIR))  approach currently owning green/yellow
phase  out  3  current phase_t

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. Asserting reset forces all of the following immediately, with no clock edge: phase OFF, L_out all 00, walk 0, ped_flash 0, active_dir 0, timer 0, ped_pend 0, walk_mask 0, after_walk 0, green_cnt 0.
- Timer:
  - Loaded with a phase duration N on the edge that enters the phase.
  - Decrements on each tick while nonzero. A load in the same cycle as a tick wins over the decrement.
  - done = (timer == 0). The transition is taken on the edge where done is high.
  - With tick tied high, a phase lasts N+1 cycles.
- OFF: all lamps 00. On start, go to ALL_RED and load RED_CLR.
- ALL_RED: all lamps 01. On done:
  - If ped_pend != 0 and after_walk == 0: go to WALK.
  - Otherwise: active_dir advances round-robin (NUM_DIR-1 wraps to 0); go to GREEN, load GREEN_MIN, set green_cnt = GREEN_MIN, clear after_walk.
  - Exception: the first GREEN after leaving OFF is approach 0, with no advance.
- GREEN: active approach 11, all others 01. On done:
  - Extend if car_present[active_dir]=1, car_present on every other approach is 0, ped_pend == 0, and green_cnt + GREEN_EXT <= GREEN_MAX. An extension reloads GREEN_EXT and adds GREEN_EXT to green_cnt.
  - Otherwise go to YELLOW and load YELLOW_T.
- YELLOW: active approach 10, others 01. On done, go to ALL_RED and load RED_CLR.
- WALK:
  - On entry: walk_mask <= ped_pend | ped_req, ped_pend <= 0, load WALK_T.
  - While in WALK: all lamps 01, walk = walk_mask.
  - On done, go to FLASH and load FLASH_T.
- FLASH:
  - All lamps 01, walk 0.
  - ped_flash is 1 on entry and toggles on each tick.
  - On done: ped_flash forced 0, after_walk <= 1, go to ALL_RED, load RED_CLR.
  - The ALL_RED after FLASH always proceeds to GREEN. This prevents walk starvation of traffic.
- Pedestrian latch: ped_pend[i] is set by ped_req[i] in every phase except OFF (ignored in OFF). Requests arriving during WALK or FLASH are held for the next cycle.
- tick low: the timer freezes and the phase holds indefinitely. Sensors are still latched.
- An illegal phase encoding recovers to OFF on the next edge.

Decomposition:
- Package traffic_pkg holds:
  - phase_t (OFF, ALL_RED, GREEN, YELLOW, WALK, FLASH)
  - lamp code constants LAMP_OFF/RED/YELLOW/GREEN
  - helper function dir_next for round-robin wrap
- Sub-module phase_timer, parametrised by TW: ports load, load_val, tick, value, done.

Test Plan:
1. Reset low, then high; start pulse, tick=1, defaults, no sensors -> ALL_RED 3 cycles; dir0 L_out=11 for 11 cycles; YELLOW 4 cycles; ALL_RED 3 cycles; then dir1 green with L_out=4'b1101.
2. car_present=2'b01 held -> dir0 green extends 5 times (green_cnt 10→30); green lasts 11+5*5=36 cycles; then YELLOW.
3. car_present=2'b11 -> no extensions; green alternates dir0, dir1, dir0, each 11 cycles.
4. ped_req[1] pulsed during dir0 GREEN, with both cars present:
   - Sequence: YELLOW → ALL_RED → WALK, walk=2'b10 for 9 cycles, all lamps 01.
   - FLASH 5 cycles, ped_flash 1,0,1,0,1.
   - ALL_RED, then dir1 GREEN, even with ped_req[0] asserted during WALK.
   - The pending request from ped_req[0] is served after dir1 yellow.
5. tick=0 for 50 cycles mid-YELLOW -> phase, L_out and timer unchanged; resumes on tick=1.
6. reset driven low mid-GREEN, between clock edges -> L_out=0, phase=OFF, ped_pend=0 immediately; stays OFF until start.
